// File: rtl/sap_pkg.sv
// Shared constants for the SAP control sequencer: opcodes, ALU operations,
// T-state encodings and control-word bit positions.
package sap_pkg;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_STA = 4'h4;
   localparam logic [3:0] OP_LDI = 4'h5;
   localparam logic [3:0] OP_JMP = 4'h6;
   localparam logic [3:0] OP_JC  = 4'h7;
   localparam logic [3:0] OP_JZ  = 4'h8;
   localparam logic [3:0] OP_INC = 4'h9;
   localparam logic [3:0] OP_HLT = 4'hB;
   localparam logic [3:0] OP_DCR = 4'hE;
   localparam logic [3:0] OP_OUT = 4'hF;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_INC = 2'b10,
      ALU_DCR = 2'b11
   } alu_op_e;

   typedef enum logic [2:0] {
      TS_T0   = 3'd0,
      TS_T1   = 3'd1,
      TS_T2   = 3'd2,
      TS_T3   = 3'd3,
      TS_T4   = 3'd4,
      TS_HALT = 3'd5
   } tstate_e;

   localparam int CW_W        = 14;
   localparam int CW_PCOUT    = 0;
   localparam int CW_PCINC    = 1;
   localparam int CW_PCLOAD   = 2;
   localparam int CW_MARLOAD  = 3;
   localparam int CW_RAMOUT   = 4;
   localparam int CW_RAMIN    = 5;
   localparam int CW_IRLOAD   = 6;
   localparam int CW_IROUT    = 7;
   localparam int CW_ALOAD    = 8;
   localparam int CW_AOUT     = 9;
   localparam int CW_BLOAD    = 10;
   localparam int CW_OUTLOAD  = 11;
   localparam int CW_ALUSTART = 12;
   localparam int CW_ALUOUT   = 13;

   typedef logic [CW_W-1:0] ctrl_word_t;

endpackage

// File: rtl/sap_microcode_decode.sv
// Combinational microcode ROM: {opcode, T-state, latched flags} to the raw
// control word, ALU operation, last-microstep and halt-request indications.
module sap_microcode_decode
   import sap_pkg::*;
(
   input  logic [3:0]      opcode,
   input  logic [2:0]      tstate,
   input  logic [1:0]      flagsq,
   output logic [CW_W-1:0] ctrl,
   output logic [1:0]      alu_op,
   output logic            last,
   output logic            halt_req
);

   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      ctrl     = '0;
      alu_op   = ALU_ADD;
      last     = 1'b0;
      halt_req = 1'b0;
      case (tstate)
         TS_T0: begin
            ctrl[CW_PCOUT]   = 1'b1;
            ctrl[CW_MARLOAD] = 1'b1;
         end
         TS_T1: begin
            ctrl[CW_RAMOUT] = 1'b1;
            ctrl[CW_IRLOAD] = 1'b1;
            ctrl[CW_PCINC]  = 1'b1;
         end
         TS_T2: begin
            last = 1'b1;
            case (opcode)
               OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                  ctrl[CW_IROUT]   = 1'b1;
                  ctrl[CW_MARLOAD] = 1'b1;
                  last             = 1'b0;
               end
               OP_LDI: begin
                  ctrl[CW_IROUT] = 1'b1;
                  ctrl[CW_ALOAD] = 1'b1;
               end
               OP_JMP: begin
                  ctrl[CW_IROUT]  = 1'b1;
                  ctrl[CW_PCLOAD] = 1'b1;
               end
               OP_JC: begin
                  ctrl[CW_IROUT]  = flagsq[0];
                  ctrl[CW_PCLOAD] = flagsq[0];
               end
               OP_JZ: begin
                  ctrl[CW_IROUT]  = flagsq[1];
                  ctrl[CW_PCLOAD] = flagsq[1];
               end
               OP_INC, OP_DCR: begin
                  ctrl[CW_ALUSTART] = 1'b1;
                  ctrl[CW_ALUOUT]   = 1'b1;
                  ctrl[CW_ALOAD]    = 1'b1;
                  alu_op            = (opcode == OP_DCR) ? ALU_DCR : ALU_INC;
               end
               OP_OUT: begin
                  ctrl[CW_AOUT]    = 1'b1;
                  ctrl[CW_OUTLOAD] = 1'b1;
               end
               OP_HLT:  halt_req = 1'b1;
               default: ;  // NOP and undefined opcodes: empty T2
            endcase
         end
         TS_T3: begin
            last = 1'b1;
            case (opcode)
               OP_LDA: begin
                  ctrl[CW_RAMOUT] = 1'b1;
                  ctrl[CW_ALOAD]  = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  ctrl[CW_RAMOUT] = 1'b1;
                  ctrl[CW_BLOAD]  = 1'b1;
                  last            = 1'b0;
               end
               OP_STA: begin
                  ctrl[CW_AOUT]  = 1'b1;
                  ctrl[CW_RAMIN] = 1'b1;
               end
               default: ;
            endcase
         end
         TS_T4: begin
            last = 1'b1;
            if (opcode == OP_ADD || opcode == OP_SUB) begin
               ctrl[CW_ALUSTART] = 1'b1;
               ctrl[CW_ALUOUT]   = 1'b1;
               ctrl[CW_ALOAD]    = 1'b1;
               alu_op            = (opcode == OP_SUB) ? ALU_SUB : ALU_ADD;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/sap_control_sequencer.sv
// SAP control sequencer: T-state register, HALT, flag latch and Run gating.
// Optional single-instruction stepping when SEQ_SINGLE_STEP_EN is defined.
module sap_control_sequencer
   import sap_pkg::*;
#(
   parameter int TSTATE_W = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                Run,
`ifdef SEQ_SINGLE_STEP_EN
   input  logic                Step,
`endif
   input  logic [3:0]          Opcode,
   input  logic [1:0]          Flags,
   output logic                PCOut,
   output logic                PCInc,
   output logic                PCLoad,
   output logic                MARLoad,
   output logic                RAMOut,
   output logic                RAMIn,
   output logic                IRLoad,
   output logic                IROut,
   output logic                ALoad,
   output logic                AOut,
   output logic                BLoad,
   output logic                OutLoad,
   output logic                AluStart,
   output logic                ALUOut,
   output logic [1:0]          Operation,
   output logic [1:0]          FlagsQ,
   output logic [TSTATE_W-1:0] TState,
   output logic                Halt
);

   tstate_e    state_q, state_d;
   logic [1:0] flags_q;
   ctrl_word_t dec_ctrl, ctrl;
   logic [1:0] dec_op;
   logic       dec_last, dec_halt;
   logic       advance, active, alu_commit;

   sap_microcode_decode u_decode (
      .opcode   (Opcode),
      .tstate   (state_q),
      .flagsq   (flags_q),
      .ctrl     (dec_ctrl),
      .alu_op   (dec_op),
      .last     (dec_last),
      .halt_req (dec_halt)
   );

`ifdef SEQ_SINGLE_STEP_EN
   logic armed_q, step_used_q, arm;

   // step_used_q blocks re-arming until Step has been seen low again.
   assign arm     = !Run && !armed_q && state_q == TS_T0 && Step && !step_used_q;
   assign advance = Run || armed_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed_q     <= 1'b0;
         step_used_q <= 1'b0;
      end else begin
         if (armed_q && dec_last)
            armed_q <= 1'b0;
         else if (arm)
            armed_q <= 1'b1;
         if (!Step)
            step_used_q <= 1'b0;
         else if (arm)
            step_used_q <= 1'b1;
      end
   end
`else
   assign advance = Run;
`endif

   // Reset also gates the word so outputs drop in the cycle rst_n falls.
   assign active     = advance && rst_n && state_q != TS_HALT;
   assign ctrl       = active ? dec_ctrl : '0;
   assign alu_commit = ctrl[CW_ALUSTART] && ctrl[CW_ALUOUT];

   always_comb begin
      state_d = state_q;
      if (active) begin
         if (dec_last) begin
            state_d = dec_halt ? TS_HALT : TS_T0;
         end else begin
            case (state_q)
               TS_T0:   state_d = TS_T1;
               TS_T1:   state_d = TS_T2;
               TS_T2:   state_d = TS_T3;
               TS_T3:   state_d = TS_T4;
               default: state_d = TS_T0;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= TS_T0;
         flags_q <= 2'b00;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values.
         state_q <= state_d;
         if (alu_commit)
            flags_q <= Flags;
      end
   end

   assign PCOut     = ctrl[CW_PCOUT];
   assign PCInc     = ctrl[CW_PCINC];
   assign PCLoad    = ctrl[CW_PCLOAD];
   assign MARLoad   = ctrl[CW_MARLOAD];
   assign RAMOut    = ctrl[CW_RAMOUT];
   assign RAMIn     = ctrl[CW_RAMIN];
   assign IRLoad    = ctrl[CW_IRLOAD];
   assign IROut     = ctrl[CW_IROUT];
   assign ALoad     = ctrl[CW_ALOAD];
   assign AOut      = ctrl[CW_AOUT];
   assign BLoad     = ctrl[CW_BLOAD];
   assign OutLoad   = ctrl[CW_OUTLOAD];
   assign AluStart  = ctrl[CW_ALUSTART];
   assign ALUOut    = ctrl[CW_ALUOUT];
   assign Operation = active ? dec_op : 2'b00;
   assign FlagsQ    = flags_q;
   // TState reads as T0 while halted; Halt distinguishes the two.
   assign TState    = (state_q == TS_HALT) ? '0 : TSTATE_W'(state_q);
   assign Halt      = (state_q == TS_HALT);

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Self-checking bench for sap_control_sequencer: directed scenarios plus a
// randomized instruction stream checked against a microprogram-table model.
module tb_sap_control_sequencer;

   logic       clk, rst_n, Run;
   logic [3:0] Opcode;
   logic [1:0] Flags;
   logic       PCOut, PCInc, PCLoad, MARLoad, RAMOut, RAMIn, IRLoad, IROut;
   logic       ALoad, AOut, BLoad, OutLoad, AluStart, ALUOut, Halt;
   logic [1:0] Operation, FlagsQ;
   logic [2:0] TState;
`ifdef SEQ_SINGLE_STEP_EN
   logic       Step;
`endif

   int checks   = 0;
   int failures = 0;

   sap_control_sequencer #(.TSTATE_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .Run(Run),
`ifdef SEQ_SINGLE_STEP_EN
      .Step(Step),
`endif
      .Opcode(Opcode), .Flags(Flags),
      .PCOut(PCOut), .PCInc(PCInc), .PCLoad(PCLoad), .MARLoad(MARLoad),
      .RAMOut(RAMOut), .RAMIn(RAMIn), .IRLoad(IRLoad), .IROut(IROut),
      .ALoad(ALoad), .AOut(AOut), .BLoad(BLoad), .OutLoad(OutLoad),
      .AluStart(AluStart), .ALUOut(ALUOut), .Operation(Operation),
      .FlagsQ(FlagsQ), .TState(TState), .Halt(Halt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Observed control word in the bench's own packing order.
   logic [15:0] cw;
   assign cw = {PCOut, PCInc, PCLoad, MARLoad, RAMOut, RAMIn, IRLoad, IROut,
                ALoad, AOut, BLoad, OutLoad, AluStart, ALUOut, Operation};

   localparam logic [15:0] M_PCOUT = 16'h8000, M_PCINC = 16'h4000, M_PCLOAD = 16'h2000;
   localparam logic [15:0] M_MARLOAD = 16'h1000, M_RAMOUT = 16'h0800, M_RAMIN = 16'h0400;
   localparam logic [15:0] M_IRLOAD = 16'h0200, M_IROUT = 16'h0100, M_ALOAD = 16'h0080;
   localparam logic [15:0] M_AOUT = 16'h0040, M_BLOAD = 16'h0020, M_OUTLOAD = 16'h0010;
   localparam logic [15:0] M_ALUSTART = 16'h0008, M_ALUOUT = 16'h0004;

   // Reference microprogram: expected word for a step of an instruction.
   function automatic logic [15:0] exp_cw(input logic [3:0] op, input int step,
                                          input logic [1:0] fq);
      logic [15:0] alu;
      alu = M_ALUSTART | M_ALUOUT | M_ALOAD;
      case (step)
         0: return M_PCOUT | M_MARLOAD;
         1: return M_RAMOUT | M_IRLOAD | M_PCINC;
         2: case (op)
               4'h1, 4'h2, 4'h3, 4'h4: return M_IROUT | M_MARLOAD;
               4'h5: return M_IROUT | M_ALOAD;
               4'h6: return M_IROUT | M_PCLOAD;
               4'h7: return fq[0] ? (M_IROUT | M_PCLOAD) : 16'h0;
               4'h8: return fq[1] ? (M_IROUT | M_PCLOAD) : 16'h0;
               4'h9: return alu | 16'd2;
               4'hE: return alu | 16'd3;
               4'hF: return M_AOUT | M_OUTLOAD;
               default: return 16'h0;
            endcase
         3: case (op)
               4'h1: return M_RAMOUT | M_ALOAD;
               4'h2, 4'h3: return M_RAMOUT | M_BLOAD;
               4'h4: return M_AOUT | M_RAMIN;
               default: return 16'h0;
            endcase
         4: return alu | ((op == 4'h3) ? 16'd1 : 16'd0);
         default: return 16'h0;
      endcase
   endfunction

   function automatic int instr_len(input logic [3:0] op);
      if (op == 4'h2 || op == 4'h3) return 5;
      if (op == 4'h1 || op == 4'h4) return 4;
      return 3;
   endfunction

   task automatic align();
      @(posedge clk); #1;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; Run = 1'b1; Opcode = 4'h2; Flags = 2'b11;
`ifdef SEQ_SINGLE_STEP_EN
      Step = 1'b0;
`endif
      #2;
      checks++; if (cw !== 16'h0) begin failures++; $display("FAIL reset_cw got=%h exp=0000", cw); end
      checks++; if (TState !== 3'd0) begin failures++; $display("FAIL reset_tstate got=%0d exp=0", TState); end
      checks++; if (FlagsQ !== 2'b00) begin failures++; $display("FAIL reset_flagsq got=%b exp=00", FlagsQ); end
      checks++; if (Halt !== 1'b0) begin failures++; $display("FAIL reset_halt got=%b exp=0", Halt); end
      Run = 1'b0; Flags = 2'b00;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_add_flags();
      align();
      Opcode = 4'h2; Run = 1'b1;
      for (int t = 0; t < 5; t++) begin
         Flags = (t == 4) ? 2'b01 : 2'b10;
         @(negedge clk);
         checks++; if (cw !== exp_cw(4'h2, t, 2'b00)) begin failures++; $display("FAIL add_cw t=%0d got=%h exp=%h", t, cw, exp_cw(4'h2, t, 2'b00)); end
         checks++; if (TState !== 3'(t)) begin failures++; $display("FAIL add_tstate got=%0d exp=%0d", TState, t); end
         align();
      end
      Run = 1'b0;
      checks++; if (FlagsQ !== 2'b01) begin failures++; $display("FAIL add_flagsq got=%b exp=01", FlagsQ); end
      checks++; if (TState !== 3'd0) begin failures++; $display("FAIL add_len got=%0d exp=0", TState); end
   endtask

   task automatic test_jc();
      apply_reset();
      align();
      Opcode = 4'h7; Run = 1'b1; Flags = 2'b11;
      for (int t = 0; t < 3; t++) begin
         @(negedge clk);
         checks++; if (cw !== exp_cw(4'h7, t, 2'b00)) begin failures++; $display("FAIL jc_nojump_cw t=%0d got=%h exp=%h", t, cw, exp_cw(4'h7, t, 2'b00)); end
         align();
      end
      checks++; if (TState !== 3'd0) begin failures++; $display("FAIL jc_len got=%0d exp=0", TState); end
      Opcode = 4'h3;
      for (int t = 0; t < 5; t++) begin
         Flags = (t == 4) ? 2'b01 : 2'b00;
         @(negedge clk);
         checks++; if (cw !== exp_cw(4'h3, t, 2'b00)) begin failures++; $display("FAIL sub_cw t=%0d got=%h exp=%h", t, cw, exp_cw(4'h3, t, 2'b00)); end
         align();
      end
      Opcode = 4'h7; Flags = 2'b00;
      align(); align();
      @(negedge clk);
      checks++; if (cw !== (M_IROUT | M_PCLOAD)) begin failures++; $display("FAIL jc_jump_cw got=%h exp=%h", cw, M_IROUT | M_PCLOAD); end
      align();
      Run = 1'b0;
   endtask

   task automatic test_run_stall();
      align();
      Opcode = 4'h1; Run = 1'b1; Flags = 2'b00;
      for (int t = 0; t < 3; t++) begin
         @(negedge clk);
         checks++; if (cw !== exp_cw(4'h1, t, 2'b01)) begin failures++; $display("FAIL lda_cw t=%0d got=%h exp=%h", t, cw, exp_cw(4'h1, t, 2'b01)); end
         align();
      end
      Run = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checks++; if (cw !== 16'h0) begin failures++; $display("FAIL stall_cw c=%0d got=%h exp=0000", c, cw); end
         checks++; if (TState !== 3'd3) begin failures++; $display("FAIL stall_tstate c=%0d got=%0d exp=3", c, TState); end
         align();
      end
      Run = 1'b1;
      @(negedge clk);
      checks++; if (cw !== (M_RAMOUT | M_ALOAD)) begin failures++; $display("FAIL resume_cw got=%h exp=%h", cw, M_RAMOUT | M_ALOAD); end
      align();
      Run = 1'b0;
      checks++; if (TState !== 3'd0) begin failures++; $display("FAIL resume_tstate got=%0d exp=0", TState); end
   endtask

   task automatic test_halt();
      apply_reset();
      align();
      Opcode = 4'h9; Run = 1'b1; Flags = 2'b11;
      repeat (3) align();
      Opcode = 4'hB; Flags = 2'b00;
      for (int t = 0; t < 3; t++) begin
         @(negedge clk);
         checks++; if (cw !== exp_cw(4'hB, t, 2'b11)) begin failures++; $display("FAIL hlt_cw t=%0d got=%h exp=%h", t, cw, exp_cw(4'hB, t, 2'b11)); end
         align();
      end
      for (int c = 0; c < 20; c++) begin
         Run = 1'($urandom_range(0, 1)); Flags = 2'($urandom_range(0, 3)); Opcode = 4'($urandom_range(0, 15));
         @(negedge clk);
         checks++; if (Halt !== 1'b1 || cw !== 16'h0) begin failures++; $display("FAIL halt_hold c=%0d halt=%b cw=%h exp halt=1 cw=0000", c, Halt, cw); end
         align();
      end
      checks++; if (FlagsQ !== 2'b11) begin failures++; $display("FAIL inc_flagsq got=%b exp=11", FlagsQ); end
      rst_n = 1'b0;
      #1;
      checks++; if (Halt !== 1'b0 || TState !== 3'd0 || FlagsQ !== 2'b00) begin failures++; $display("FAIL halt_reset halt=%b ts=%0d fq=%b exp 0/0/00", Halt, TState, FlagsQ); end
      Run = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_undef_and_mid_reset();
      align();
      Opcode = 4'hC; Run = 1'b1; Flags = 2'b11;
      for (int t = 0; t < 3; t++) begin
         @(negedge clk);
         checks++; if (cw !== exp_cw(4'hC, t, 2'b00)) begin failures++; $display("FAIL undef_cw t=%0d got=%h exp=%h", t, cw, exp_cw(4'hC, t, 2'b00)); end
         align();
      end
      checks++; if (TState !== 3'd0) begin failures++; $display("FAIL undef_len got=%0d exp=0", TState); end
      Opcode = 4'h2;
      repeat (4) align();
      @(negedge clk);
      checks++; if (cw !== exp_cw(4'h2, 4, 2'b00)) begin failures++; $display("FAIL mid_t4_cw got=%h exp=%h", cw, exp_cw(4'h2, 4, 2'b00)); end
      #1;
      rst_n = 1'b0;
      #1;
      checks++; if (cw !== 16'h0) begin failures++; $display("FAIL mid_reset_cw got=%h exp=0000", cw); end
      align();
      checks++; if (FlagsQ !== 2'b00 || TState !== 3'd0) begin failures++; $display("FAIL mid_reset_state fq=%b ts=%0d exp 00/0", FlagsQ, TState); end
      Run = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_random();
      logic [3:0]  op;
      logic [1:0]  fq;
      logic [15:0] e;
      int step, n;
      bit need_new;
      fq = 2'b00; step = 0; n = 0; need_new = 1'b1; op = 4'h0;
      apply_reset();
      align();
      for (int c = 0; c < 3000 && n < 40; c++) begin
         if (need_new) begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'hB) op = 4'h0;
            Opcode = op; need_new = 1'b0;
         end
         Run = ($urandom_range(0, 4) != 0);
         Flags = 2'($urandom_range(0, 3));
         e = Run ? exp_cw(op, step, fq) : 16'h0;
         @(negedge clk);
         checks++;
         if (cw !== e || TState !== 3'(step) || FlagsQ !== fq || Halt !== 1'b0) begin
            failures++;
            $display("FAIL rand op=%h step=%0d cw=%h exp=%h ts=%0d fq=%b expfq=%b", op, step, cw, e, TState, FlagsQ, fq);
         end
         align();
         if (Run) begin
            if ((e & M_ALUSTART) != 0 && (e & M_ALUOUT) != 0) fq = Flags;
            if (step == instr_len(op) - 1) begin
               step = 0; n++; need_new = 1'b1;
            end else begin
               step++;
            end
         end
      end
      Run = 1'b0;
      checks++; if (n != 40) begin failures++; $display("FAIL rand_progress got=%0d exp=40", n); end
   endtask

`ifdef SEQ_SINGLE_STEP_EN
   task automatic test_single_step();
      int busy, aload;
      busy = 0; aload = 0;
      apply_reset();
      align();
      Run = 1'b0; Opcode = 4'h5; Step = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (cw != 16'h0) busy++;
         if ((cw & M_ALOAD) != 0) aload++;
         align();
      end
      Step = 1'b0;
      checks++; if (busy != 3) begin failures++; $display("FAIL step_busy got=%0d exp=3", busy); end
      checks++; if (aload != 1) begin failures++; $display("FAIL step_aload got=%0d exp=1", aload); end
      checks++; if (TState !== 3'd0) begin failures++; $display("FAIL step_tstate got=%0d exp=0", TState); end
   endtask
`endif

   initial begin
      test_reset();
      test_add_flags();
      test_jc();
      test_run_stall();
      test_halt();
      test_undef_and_mid_reset();
      test_random();
`ifdef SEQ_SINGLE_STEP_EN
      test_single_step();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
